load_store_unit: RTL and testbench

Sits between the execute stage and memory_manager and sequences every data-memory access. Accepts one load/store request at a time over a valid/ready handshake and translates banked-window addresses using bank_0/bank_1/bank_sel. Splits 16-bit "pair" accesses into two byte accesses, drives mem_op/mem_addr/mem_wdata, and returns load data with a one-cycle response strobe.

---
 rtl/load_store_unit.sv | 203 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequences every data-memory access between the execute stage
//            and the memory manager. Accepts one load/store per valid/ready
//            handshake, translates banked-window addresses once at
//            acceptance, splits 16-bit pair accesses into two byte accesses
//            and returns load data with a one-cycle response strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   req_valid_i  request present (held stable until accepted)
//   req_ready_o  unit can accept a request (IDLE only)
//   req_write_i  1 = store, 0 = load
//   req_pair_i   1 = 16-bit access, 0 = single byte
//   req_addr_i   logical byte address
//   req_wdata_i  store data, low byte at the lower address
//   rsp_valid_o  one-cycle completion strobe
//   rsp_rdata_o  load data (zero for stores), held until the next response
//   mem_op_o     MEM_NONE / MEM_READ / MEM_WRITE to the memory manager
//   mem_addr_o   physical byte address
//   mem_wdata_o  write byte
//   mem_rdata_i  combinational read data from the memory manager
//   bank_0_i     physical base of bank 0
//   bank_1_i     physical base of bank 1
//   bank_sel_i   0 selects bank_0_i, 1 selects bank_1_i
//   busy_o       high in any state other than IDLE
// ============================================================================
module load_store_unit #(
  parameter int unsigned                WORD_SIZE = 8,
  parameter logic [WORD_SIZE-1:0]       WIN_BASE  = 8'hC0,
  parameter int unsigned                WIN_SIZE  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic                      req_pair_i,
  input  logic [WORD_SIZE-1:0]      req_addr_i,
  input  logic [2*WORD_SIZE-1:0]    req_wdata_i,
  output logic                      rsp_valid_o,
  output logic [2*WORD_SIZE-1:0]    rsp_rdata_o,
  output logic [1:0]                mem_op_o,
  output logic [WORD_SIZE-1:0]      mem_addr_o,
  output logic [WORD_SIZE-1:0]      mem_wdata_o,
  input  logic [WORD_SIZE-1:0]      mem_rdata_i,
  input  logic [WORD_SIZE-1:0]      bank_0_i,
  input  logic [WORD_SIZE-1:0]      bank_1_i,
  input  logic                      bank_sel_i,
  output logic                      busy_o
);

  // Memory operation codes shared with the memory manager.
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [WORD_SIZE:0]   WIN_SIZE_W = WIN_SIZE[WORD_SIZE:0];
  localparam logic [WORD_SIZE-1:0] ADDR_ONE   = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [WORD_SIZE-1:0] BYTE_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic                     pair_q, pair_d;
  logic [WORD_SIZE-1:0]     phys_q, phys_d;
  logic [WORD_SIZE-1:0]     wdata_hi_q, wdata_hi_d;
  logic [WORD_SIZE-1:0]     rdata_lo_q, rdata_lo_d;
  logic [2*WORD_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]               mem_op_q, mem_op_d;
  logic [WORD_SIZE-1:0]     mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]     mem_wdata_q, mem_wdata_d;

  // --------------------------------------------------------------------------
  // Address translation of the incoming request. The offset is computed
  // first so the window test never needs an address wider than WORD_SIZE+1,
  // even if the window touches the top of the address space.
  // --------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] win_off;
  logic                 in_win;
  logic [WORD_SIZE-1:0] bank_base;
  logic [WORD_SIZE-1:0] req_phys;

  assign win_off   = req_addr_i - WIN_BASE;
  assign in_win    = (req_addr_i >= WIN_BASE) && ({1'b0, win_off} < WIN_SIZE_W);
  assign bank_base = bank_sel_i ? bank_1_i : bank_0_i;
  assign req_phys  = in_win ? (bank_base + win_off) : req_addr_i;

  // --------------------------------------------------------------------------
  // State and datapath registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      pair_q      <= 1'b0;
      phys_q      <= '0;
      wdata_hi_q  <= '0;
      rdata_lo_q  <= '0;
      rsp_rdata_q <= '0;
      mem_op_q    <= MEM_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      pair_q      <= pair_d;
      phys_q      <= phys_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_lo_q  <= rdata_lo_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The memory interface is registered, so each state
  // prepares the bus values for the state it is about to enter.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    pair_d      = pair_q;
    phys_d      = phys_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_lo_d  = rdata_lo_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          write_d    = req_write_i;
          pair_d     = req_pair_i;
          phys_d     = req_phys;
          wdata_hi_d = req_wdata_i[2*WORD_SIZE-1:WORD_SIZE];
          mem_op_d   = req_write_i ? MEM_WRITE : MEM_READ;
          mem_addr_d = req_phys;
          if (req_write_i) begin
            mem_wdata_d = req_wdata_i[WORD_SIZE-1:0];
          end
          state_d = ST_ACC0;
        end
      end

      ST_ACC0: begin
        if (!write_q) begin
          rdata_lo_d = mem_rdata_i;
        end
        if (pair_q) begin
          // Second byte: plain increment of the already-translated address.
          mem_addr_d = phys_q + ADDR_ONE;
          if (write_q) begin
            mem_wdata_d = wdata_hi_q;
          end
          state_d = ST_ACC1;
        end else begin
          mem_op_d    = MEM_NONE;
          rsp_rdata_d = write_q ? '0 : {BYTE_ZERO, mem_rdata_i};
          state_d     = ST_RESP;
        end
      end

      ST_ACC1: begin
        mem_op_d    = MEM_NONE;
        rsp_rdata_d = write_q ? '0 : {mem_rdata_i, rdata_lo_q};
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_op_d = MEM_NONE;
      end
    endcase
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_op_o    = mem_op_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit with a
//            256-byte memory model standing in for the memory manager.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_pair;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  mem_op;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  bank_0;
  logic [7:0]  bank_1;
  logic        bank_sel;
  logic        busy;

  int total;
  int bad;

  logic [7:0] mem [256];

  load_store_unit #(
    .WORD_SIZE (8),
    .WIN_BASE  (8'hC0),
    .WIN_SIZE  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_pair_i  (req_pair),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .mem_op_o    (mem_op),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .bank_0_i    (bank_0),
    .bank_1_i    (bank_1),
    .bank_sel_i  (bank_sel),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory manager stand-in: combinational read, write at the clock edge;
  // a write presented while reset is asserted is discarded.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (!reset && mem_op == MEM_WRITE) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic present(input logic wr, input logic pr, input logic [7:0] a, input logic [15:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_pair  = pr;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h1);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'h0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'h0);
    chk({tag, "_op"},    32'(mem_op),    32'(MEM_NONE));
    chk({tag, "_addr"},  32'(mem_addr),  32'h0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_busy"},  32'(busy),      32'h0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_pair  = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    bank_0    = 8'h40;
    bank_1    = 8'h80;
    bank_sel  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h10] <= 8'h5A;
    mem[8'h43] <= 8'h11;
    mem[8'h83] <= 8'h22;
    mem[8'hD0] <= 8'h33;
    mem[8'hFF] <= 8'h12;
    mem[8'h00] <= 8'h34;
    mem[8'h07] <= 8'h77;
    mem[8'h31] <= 8'h55;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk_rst_vals("reset");
    reset = 1'b0;

    // ---------------- single load from 0x10 ----------------
    present(1'b0, 1'b0, 8'h10, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("ld1_op",    32'(mem_op),    32'(MEM_READ));
    chk("ld1_addr",  32'(mem_addr),  32'h10);
    chk("ld1_ready", 32'(req_ready), 32'h0);
    chk("ld1_busy",  32'(busy),      32'h1);
    chk("ld1_rspv0", 32'(rsp_valid), 32'h0);
    tick();
    chk("ld1_rspv",  32'(rsp_valid), 32'h1);
    chk("ld1_rdata", 32'(rsp_rdata), 32'h005A);
    chk("ld1_opn",   32'(mem_op),    32'(MEM_NONE));
    tick();
    chk("ld1_idle_busy", 32'(busy),      32'h0);
    chk("ld1_idle_rspv", 32'(rsp_valid), 32'h0);
    chk("ld1_hold",      32'(rsp_rdata), 32'h005A);

    // ---------------- pair store 0xBEEF to 0x20 ----------------
    present(1'b1, 1'b1, 8'h20, 16'hBEEF);
    tick();
    req_valid = 1'b0;
    chk("st2_op0",   32'(mem_op),    32'(MEM_WRITE));
    chk("st2_addr0", 32'(mem_addr),  32'h20);
    chk("st2_wd0",   32'(mem_wdata), 32'hEF);
    tick();
    chk("st2_op1",   32'(mem_op),    32'(MEM_WRITE));
    chk("st2_addr1", 32'(mem_addr),  32'h21);
    chk("st2_wd1",   32'(mem_wdata), 32'hBE);
    chk("st2_ready", 32'(req_ready), 32'h0);
    tick();
    chk("st2_rspv",  32'(rsp_valid), 32'h1);
    chk("st2_rdata", 32'(rsp_rdata), 32'h0000);
    chk("st2_opn",   32'(mem_op),    32'(MEM_NONE));
    chk("st2_m20",   32'(mem[8'h20]), 32'hEF);
    chk("st2_m21",   32'(mem[8'h21]), 32'hBE);
    tick();

    // ---------------- pair load of 0x20 ----------------
    present(1'b0, 1'b1, 8'h20, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("ld2_addr0", 32'(mem_addr), 32'h20);
    tick();
    chk("ld2_addr1", 32'(mem_addr), 32'h21);
    chk("ld2_rspv0", 32'(rsp_valid), 32'h0);
    tick();
    chk("ld2_rspv",  32'(rsp_valid), 32'h1);
    chk("ld2_rdata", 32'(rsp_rdata), 32'hBEEF);
    tick();

    // ---------------- window translation ----------------
    bank_sel = 1'b0;
    present(1'b0, 1'b0, 8'hC3, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("win0_addr", 32'(mem_addr), 32'h43);
    tick();
    chk("win0_rdata", 32'(rsp_rdata), 32'h0011);
    tick();

    bank_sel = 1'b1;
    present(1'b0, 1'b0, 8'hC3, 16'h0000);
    tick();
    req_valid = 1'b0;
    bank_sel  = 1'b0;   // must not affect the request already in flight
    chk("win1_addr", 32'(mem_addr), 32'h83);
    tick();
    chk("win1_rdata", 32'(rsp_rdata), 32'h0022);
    tick();

    present(1'b0, 1'b0, 8'hD0, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("nowin_addr", 32'(mem_addr), 32'hD0);
    tick();
    chk("nowin_rdata", 32'(rsp_rdata), 32'h0033);
    tick();

    // ---------------- wrap boundaries ----------------
    present(1'b0, 1'b1, 8'hFF, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("wrap_addr0", 32'(mem_addr), 32'hFF);
    tick();
    chk("wrap_addr1", 32'(mem_addr), 32'h00);
    tick();
    chk("wrap_rdata", 32'(rsp_rdata), 32'h3412);
    tick();

    bank_1   = 8'hF8;
    bank_sel = 1'b1;
    present(1'b0, 1'b0, 8'hCF, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("bwrap_addr", 32'(mem_addr), 32'h07);
    tick();
    chk("bwrap_rdata", 32'(rsp_rdata), 32'h0077);
    tick();
    bank_sel = 1'b0;

    // ---------------- back-to-back handshake ----------------
    present(1'b0, 1'b0, 8'h10, 16'h0000);
    tick();
    chk("hs_acc0_ready", 32'(req_ready), 32'h0);
    chk("hs_acc0_addr",  32'(mem_addr),  32'h10);
    present(1'b0, 1'b0, 8'h07, 16'h0000);
    tick();
    chk("hs_resp_ready", 32'(req_ready), 32'h0);
    chk("hs_resp_rspv",  32'(rsp_valid), 32'h1);
    chk("hs_resp_rdata", 32'(rsp_rdata), 32'h005A);
    tick();
    chk("hs_idle_ready", 32'(req_ready), 32'h1);
    chk("hs_idle_op",    32'(mem_op),    32'(MEM_NONE));
    tick();
    req_valid = 1'b0;
    chk("hs_2nd_op",   32'(mem_op),   32'(MEM_READ));
    chk("hs_2nd_addr", 32'(mem_addr), 32'h07);
    tick();
    chk("hs_2nd_rdata", 32'(rsp_rdata), 32'h0077);
    tick();

    // ---------------- reset during ACC1 of a pair store ----------------
    present(1'b1, 1'b1, 8'h30, 16'h6699);
    tick();
    req_valid = 1'b0;
    chk("rst_acc0_addr", 32'(mem_addr), 32'h30);
    tick();
    chk("rst_acc1_addr", 32'(mem_addr), 32'h31);
    reset = 1'b1;
    tick();
    chk_rst_vals("midrst");
    chk("midrst_m30", 32'(mem[8'h30]), 32'h99);
    chk("midrst_m31", 32'(mem[8'h31]), 32'h55);
    reset = 1'b0;
    tick();
    chk("post_rst_rspv", 32'(rsp_valid), 32'h0);
    tick();
    chk("post_rst_rspv2", 32'(rsp_valid), 32'h0);
    chk("post_rst_busy",  32'(busy),      32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
